// File: rtl/instr_staticisor.sv
// -----------------------------------------------------------------------------
// instr_staticisor
//
// Bit-serial instruction staticisor. Sits directly upstream of the line and
// function staticisors. One WORD_LENGTH-bit instruction word is shifted in
// from the serial store read bus. When the last bit arrives, the word is
// split into address, B-tube, spare and function fields. Those fields are
// held stable until the next completed capture or a reset.
//
// Field layout (LSB upward):
//   [INSTR_ADDR_BITS-1:0]  address  -> s_out (line staticisor `s` input)
//   next INSTR_B_BITS      B-tube   -> b_out
//   next INSTR_SPARE_BITS  padding  -> spare_out
//   top INSTR_FUNCTION_BITS function -> f_out (function staticisor)
//
// Ports:
//   clk         in   system clock; all state changes on the rising edge
//   rst_n       in   asynchronous active-low reset
//   bit_in      in   serial data bit from the store read bus
//   bit_valid   in   bit_in is valid this cycle
//   word_start  in   with bit_valid: this bit is bit 0 of a word
//   load_en     in   sampled with word_start; 1 = capture this word
//   s_out       out  held address field
//   b_out       out  held B-tube field
//   spare_out   out  held spare field
//   f_out       out  held function field
//   stat_valid  out  one-cycle pulse when the held fields take a new word
//   busy        out  a capture is in progress
//   frame_err   out  one-cycle pulse when a word_start cuts a word short
//
// Optional feature:
//   INSTR_STAT_MSB_FIRST_EN  when defined, serial bits arrive MSB first. The
//                            first bit lands at WORD_LENGTH-1 and the bit
//                            position counts downward. Timing is unchanged.
//                            When undefined, bits arrive LSB first.
// -----------------------------------------------------------------------------
module instr_staticisor #(
    parameter int WORD_LENGTH         = 20,
    parameter int INSTR_ADDR_BITS     = 10,
    parameter int INSTR_B_BITS        = 3,
    parameter int INSTR_SPARE_BITS    = 1,
    parameter int INSTR_FUNCTION_BITS = 6
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           bit_in,
    input  logic                           bit_valid,
    input  logic                           word_start,
    input  logic                           load_en,
    output logic [INSTR_ADDR_BITS-1:0]     s_out,
    output logic [INSTR_B_BITS-1:0]        b_out,
    output logic [INSTR_SPARE_BITS-1:0]    spare_out,
    output logic [INSTR_FUNCTION_BITS-1:0] f_out,
    output logic                           stat_valid,
    output logic                           busy,
    output logic                           frame_err
);

    // Width of the bit-position counter. It only needs to index 0..WORD_LENGTH-1.
    localparam int CNT_W = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;

    // Field boundaries inside the assembled word.
    localparam int B_LSB     = INSTR_ADDR_BITS;
    localparam int SPARE_LSB = B_LSB + INSTR_B_BITS;
    localparam int F_LSB     = SPARE_LSB + INSTR_SPARE_BITS;

    // Bit ordering. FIRST_POS is where the word_start bit lands. NEXT_POS is
    // the counter value after that first bit. LAST_POS is the position whose
    // arrival completes the word.
`ifdef INSTR_STAT_MSB_FIRST_EN
    localparam logic [CNT_W-1:0] FIRST_POS = CNT_W'(WORD_LENGTH - 1);
    localparam logic [CNT_W-1:0] NEXT_POS  = CNT_W'(WORD_LENGTH - 2);
    localparam logic [CNT_W-1:0] LAST_POS  = CNT_W'(0);
`else
    localparam logic [CNT_W-1:0] FIRST_POS = CNT_W'(0);
    localparam logic [CNT_W-1:0] NEXT_POS  = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAST_POS  = CNT_W'(WORD_LENGTH - 1);
`endif

    // Reject field layouts that do not tile the word exactly.
    if (INSTR_ADDR_BITS + INSTR_B_BITS + INSTR_SPARE_BITS + INSTR_FUNCTION_BITS
        != WORD_LENGTH) begin : g_bad_field_widths
        $error("instr_staticisor: field widths must sum to WORD_LENGTH");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                         state_q, state_d;
    logic [WORD_LENGTH-1:0]         shreg_q, shreg_d;
    logic [CNT_W-1:0]               pos_q, pos_d;
    logic [INSTR_ADDR_BITS-1:0]     s_q, s_d;
    logic [INSTR_B_BITS-1:0]        b_q, b_d;
    logic [INSTR_SPARE_BITS-1:0]    spare_q, spare_d;
    logic [INSTR_FUNCTION_BITS-1:0] f_q, f_d;
    logic                           stat_valid_q, stat_valid_d;
    logic                           frame_err_q, frame_err_d;

    // Position that follows pos_q in the current bit order.
    logic [CNT_W-1:0]               pos_step;

`ifdef INSTR_STAT_MSB_FIRST_EN
    assign pos_step = pos_q - CNT_W'(1);
`else
    assign pos_step = pos_q + CNT_W'(1);
`endif

    // -------------------------------------------------------------------------
    // Next-state and datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default first. No path through the case
        // can then leave a value unassigned, so no latch can be inferred.
        state_d      = state_q;
        shreg_d      = shreg_q;
        pos_d        = pos_q;
        s_d          = s_q;
        b_d          = b_q;
        spare_d      = spare_q;
        f_d          = f_q;
        stat_valid_d = 1'b0;
        frame_err_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A word_start with load_en low is some other word on the
                // bus. It is ignored.
                if (bit_valid && word_start && load_en) begin
                    shreg_d            = '0;
                    shreg_d[FIRST_POS] = bit_in;
                    pos_d              = NEXT_POS;
                    state_d            = SHIFT;
                end
            end

            SHIFT: begin
                if (bit_valid) begin
                    if (word_start) begin
                        // Short word: report it. The held fields stay put.
                        // The new word either restarts the capture or sends
                        // the block back to idle.
                        frame_err_d = 1'b1;
                        if (load_en) begin
                            shreg_d            = '0;
                            shreg_d[FIRST_POS] = bit_in;
                            pos_d              = NEXT_POS;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        shreg_d[pos_q] = bit_in;
                        if (pos_q == LAST_POS) begin
                            // The word is complete, counting this cycle's
                            // bit. Publish it on the next edge. This is the
                            // only point where the held fields change.
                            s_d          = shreg_d[INSTR_ADDR_BITS-1:0];
                            b_d          = shreg_d[SPARE_LSB-1:B_LSB];
                            spare_d      = shreg_d[F_LSB-1:SPARE_LSB];
                            f_d          = shreg_d[WORD_LENGTH-1:F_LSB];
                            stat_valid_d = 1'b1;
                            state_d      = IDLE;
                        end else begin
                            pos_d = pos_step;
                        end
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: the shift register and counter are cleared by reset along with
    // the control state. An abandoned capture can then never leak stale bits
    // into a later word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            pos_q        <= '0;
            s_q          <= '0;
            b_q          <= '0;
            spare_q      <= '0;
            f_q          <= '0;
            stat_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments. Every register samples the
            // pre-edge value of every other, whatever the statement order.
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            pos_q        <= pos_d;
            s_q          <= s_d;
            b_q          <= b_d;
            spare_q      <= spare_d;
            f_q          <= f_d;
            stat_valid_q <= stat_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign s_out      = s_q;
    assign b_out      = b_q;
    assign spare_out  = spare_q;
    assign f_out      = f_q;
    assign stat_valid = stat_valid_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q == SHIFT);

endmodule

// File: tb/tb_instr_staticisor.sv
// -----------------------------------------------------------------------------
// tb_instr_staticisor
//
// Directed self-checking bench for instr_staticisor with the default field
// layout (20-bit word: 10/3/1/6). Inputs change 1 ns after a rising edge, and
// outputs are read at that same point. An output read right after an edge
// therefore reflects the bit presented during the cycle that just ended.
// Serial bit order follows INSTR_STAT_MSB_FIRST_EN, as in the design.
// -----------------------------------------------------------------------------
module tb_instr_staticisor;

    localparam int W = 20;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bit_in;
    logic        bit_valid;
    logic        word_start;
    logic        load_en;
    logic [9:0]  s_out;
    logic [2:0]  b_out;
    logic [0:0]  spare_out;
    logic [5:0]  f_out;
    logic        stat_valid;
    logic        busy;
    logic        frame_err;

    int checks   = 0;
    int failures = 0;
    int sv_count = 0;   // stat_valid pulses seen
    int fe_count = 0;   // frame_err pulses seen

    instr_staticisor dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .word_start (word_start),
        .load_en    (load_en),
        .s_out      (s_out),
        .b_out      (b_out),
        .spare_out  (spare_out),
        .f_out      (f_out),
        .stat_valid (stat_valid),
        .busy       (busy),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    // Pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (stat_valid === 1'b1) sv_count++;
        if (frame_err === 1'b1)  fe_count++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Position of the i-th serial bit within the word.
    function automatic int pos_of(input int i);
`ifdef INSTR_STAT_MSB_FIRST_EN
        return W - 1 - i;
`else
        return i;
`endif
    endfunction

    task automatic idle(input int n);
        bit_valid  = 1'b0;
        word_start = 1'b0;
        for (int k = 0; k < n; k++) tick();
    endtask

    // Send serial bits 0..nbits-1 of w. Bit 0 carries word_start and le.
    // After serial index stall_a or stall_b (if >= 0), three idle cycles are
    // inserted and busy is checked in each of them.
    task automatic send_bits(input logic [W-1:0] w, input logic le, input int nbits,
                             input int stall_a, input int stall_b);
        for (int i = 0; i < nbits; i++) begin
            bit_valid  = 1'b1;
            bit_in     = w[pos_of(i)];
            word_start = (i == 0);
            load_en    = (i == 0) ? le : 1'b0;
            tick();
            if (i == stall_a || i == stall_b) begin
                bit_valid  = 1'b0;
                word_start = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    tick();
                    check("stall_busy", 32'(busy), 32'd1);
                end
            end
        end
        bit_valid  = 1'b0;
        word_start = 1'b0;
        load_en    = 1'b0;
    endtask

    task automatic check_fields(input string tag, input logic [9:0] s, input logic [2:0] b,
                                input logic sp, input logic [5:0] f);
        check({tag, "_s"},     32'(s_out),     32'(s));
        check({tag, "_b"},     32'(b_out),     32'(b));
        check({tag, "_spare"}, 32'(spare_out), 32'(sp));
        check({tag, "_f"},     32'(f_out),     32'(f));
    endtask

    int sv_before;
    int fe_before;

    initial begin
        rst_n      = 1'b0;
        bit_in     = 1'b0;
        bit_valid  = 1'b0;
        word_start = 1'b0;
        load_en    = 1'b0;
        #22;
        rst_n = 1'b1;

        // ---------------- reset then idle ----------------
        idle(10);
        check_fields("reset", 10'h0, 3'd0, 1'b0, 6'h0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_sv_pulses", 32'(sv_count), 32'd0);
        check("reset_fe_pulses", 32'(fe_count), 32'd0);

        // ---------------- contiguous capture of 0x856A5 ----------------
        send_bits(20'h856A5, 1'b1, 1, -1, -1);
        check("cap_busy_after_bit0", 32'(busy), 32'd1);
        send_bits(20'h856A5, 1'b0, 0, -1, -1);
        // Send bits 1..18 by hand so the cycle before completion can be checked.
        for (int i = 1; i < W - 1; i++) begin
            bit_valid = 1'b1; bit_in = 20'h856A5 >> pos_of(i) & 1'b1; word_start = 1'b0;
            tick();
        end
        check("cap_no_early_sv", 32'(stat_valid), 32'd0);
        check_fields("cap_partial_hidden", 10'h0, 3'd0, 1'b0, 6'h0);
        bit_valid = 1'b1; bit_in = 20'h856A5 >> pos_of(W - 1) & 1'b1;
        tick();
        bit_valid = 1'b0;
        check("cap_sv", 32'(stat_valid), 32'd1);
        check("cap_busy_done", 32'(busy), 32'd0);
        check_fields("cap", 10'h2A5, 3'd5, 1'b0, 6'h21);
        tick();
        check("cap_sv_one_cycle", 32'(stat_valid), 32'd0);
        check("cap_sv_pulses", 32'(sv_count), 32'd1);

        // ---------------- stalls after serial bits 4 and 12 ----------------
        idle(2);
        sv_before = sv_count;
        send_bits(20'h856A5, 1'b1, W - 1, 4, 12);
        check("stall_no_early_sv", 32'(stat_valid), 32'd0);
        check("stall_busy_before_last", 32'(busy), 32'd1);
        send_bits(20'h856A5 >> pos_of(W - 1), 1'b0, 0, -1, -1);
        bit_valid = 1'b1; bit_in = 20'h856A5 >> pos_of(W - 1) & 1'b1;
        tick();
        bit_valid = 1'b0;
        check("stall_sv", 32'(stat_valid), 32'd1);
        check_fields("stall", 10'h2A5, 3'd5, 1'b0, 6'h21);
        tick();
        check("stall_sv_pulses", sv_count - sv_before, 32'd1);

        // ---------------- framing: 7 bits of 0xFFFFF, then 0x00001 ----------------
        idle(2);
        fe_before = fe_count;
        sv_before = sv_count;
        send_bits(20'hFFFFF, 1'b1, 7, -1, -1);
        // First bit of the new word cuts the old one short.
        bit_valid = 1'b1; bit_in = 1'(20'h00001 >> pos_of(0)); word_start = 1'b1; load_en = 1'b1;
        tick();
        word_start = 1'b0; load_en = 1'b0;
        check("frame_err_pulse", 32'(frame_err), 32'd1);
        check("frame_busy", 32'(busy), 32'd1);
        check_fields("frame_hold", 10'h2A5, 3'd5, 1'b0, 6'h21);
        for (int i = 1; i < W; i++) begin
            bit_valid = 1'b1; bit_in = 1'(20'h00001 >> pos_of(i));
            tick();
            if (i == 1) check("frame_err_one_cycle", 32'(frame_err), 32'd0);
            if (i == W - 2) check_fields("frame_hold_late", 10'h2A5, 3'd5, 1'b0, 6'h21);
        end
        bit_valid = 1'b0;
        check("frame_sv", 32'(stat_valid), 32'd1);
        check_fields("frame_final", 10'h001, 3'd0, 1'b0, 6'h00);
        check("frame_fe_pulses", fe_count - fe_before, 32'd1);

        // ---------------- back-to-back: new word starts in the stat_valid cycle ----------------
        send_bits(20'h856A5, 1'b1, W, -1, -1);
        check("b2b_sv", 32'(stat_valid), 32'd1);
        check_fields("b2b", 10'h2A5, 3'd5, 1'b0, 6'h21);
        tick();
        check("b2b_sv_pulses", sv_count - sv_before, 32'd2);

        // ---------------- ignore and hold: load_en=0 word ----------------
        sv_before = sv_count;
        send_bits(20'h12345, 1'b0, 1, -1, -1);
        check("ign_busy", 32'(busy), 32'd0);
        send_bits(20'h12345, 1'b0, W, -1, -1);
        tick();
        check("ign_busy_end", 32'(busy), 32'd0);
        check("ign_no_sv", sv_count - sv_before, 32'd0);
        check_fields("ign_hold", 10'h2A5, 3'd5, 1'b0, 6'h21);

        // ---------------- reset mid-capture ----------------
        idle(1);
        sv_before = sv_count;
        send_bits(20'h856A5, 1'b1, 11, -1, -1);
        #2;
        rst_n = 1'b0;
        #1;
        check_fields("midrst_async", 10'h0, 3'd0, 1'b0, 6'h0);
        check("midrst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("midrst_no_sv", sv_count - sv_before, 32'd0);
        send_bits(20'h856A5, 1'b1, W, -1, -1);
        check("midrst_recap_sv", 32'(stat_valid), 32'd1);
        check_fields("midrst_recap", 10'h2A5, 3'd5, 1'b0, 6'h21);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
